// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: pipeline-side and data-memory-side signals of the MEM-stage controller.
// Latency: none, wires only.
// Backpressure: stall towards the pipeline; mem_req held until mem_ack towards memory.
interface mem_stage_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // pipeline -> controller
  logic            op_valid;
  logic            is_load;
  logic            is_store;
  logic [2:0]      funct3;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   st_data;
  logic            flush;
  // controller -> pipeline
  logic            stall;
  logic [DW-1:0]   ld_data;
  logic            ld_valid;
  logic            fault;
  logic [1:0]      fault_code;
  // controller <-> data memory
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  // controller view
  modport slave (
    input  op_valid, is_load, is_store, funct3, addr, st_data, flush,
    input  mem_ack, mem_rdata,
    output stall, ld_data, ld_valid, fault, fault_code,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // pipeline plus memory view
  modport master (
    output op_valid, is_load, is_store, funct3, addr, st_data, flush,
    output mem_ack, mem_rdata,
    input  stall, ld_data, ld_valid, fault, fault_code,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: RISC-V MEM-stage load/store sequencer (width/alignment check, lane placement, timeout).
// Latency: accept -> mem_req next cycle; ld_valid the cycle after mem_ack; fault one cycle after its cause.
// Backpressure: stall from accept through the ack cycle; mem_req held until mem_ack, timeout or reset.
module mem_stage_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  mem_stage_ctrl_if.slave bus
);

  localparam int BW = DW / 8;
  localparam int LW = $clog2(BW);
  // counter only has to reach TIMEOUT-1
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            flush_q;
  logic            is_load_q;
  logic [2:0]      f3_q;
  logic [LW-1:0]   off_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   ld_data_q;
  logic            fault_q;
  logic [1:0]      fault_code_q;

  logic            accept, width_ok, align_ok, go_req, timeout;
  logic [LW-1:0]   off_in;
  logic [7:0]      size_mask, be_full;
  logic [DW-1:0]   wdata_lane, rd_sh, ld_ext;

  assign off_in  = bus.addr[LW-1:0];
  assign accept  = (state_q == IDLE) && bus.op_valid && (bus.is_load ^ bus.is_store) && !bus.flush;
  assign go_req  = accept && width_ok && align_ok;
  assign timeout = (state_q == REQ) && !bus.mem_ack && (cnt_q == CW'(TIMEOUT - 1));

  // legality and natural alignment of the presented access; illegal width takes precedence
  always_comb begin
    width_ok = 1'b0;
    align_ok = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: width_ok = 1'b1;
      3'b011:                 width_ok = (DW == 64);
      3'b100, 3'b101:         width_ok = bus.is_load;
      3'b110:                 width_ok = bus.is_load && (DW == 64);
      default:                width_ok = 1'b0;
    endcase
    case (bus.funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = !bus.addr[0];
      2'b10:   align_ok = (bus.addr[1:0] == 2'b00);
      default: align_ok = (bus.addr[2:0] == 3'b000);
    endcase
  end

  // byte-enable mask and replicated write data for the presented access
  always_comb begin
    size_mask  = 8'h00;
    wdata_lane = bus.st_data;
    case (bus.funct3[1:0])
      2'b00: begin
        size_mask  = 8'h01;
        wdata_lane = {BW{bus.st_data[7:0]}};
      end
      2'b01: begin
        size_mask  = 8'h03;
        wdata_lane = {(DW/16){bus.st_data[15:0]}};
      end
      2'b10: begin
        size_mask  = 8'h0F;
        wdata_lane = {(DW/32){bus.st_data[31:0]}};
      end
      default: begin
        size_mask  = 8'hFF;
        wdata_lane = bus.st_data;
      end
    endcase
    be_full = size_mask << off_in;
  end

  // lane shift and sign/zero extension of the returning read data
  always_comb begin
    rd_sh  = bus.mem_rdata >> {off_q, 3'b000};
    ld_ext = rd_sh;
    case (f3_q)
      3'b000:  ld_ext = DW'($signed(rd_sh[7:0]));
      3'b001:  ld_ext = DW'($signed(rd_sh[15:0]));
      3'b010:  ld_ext = DW'($signed(rd_sh[31:0]));
      3'b100:  ld_ext = DW'(rd_sh[7:0]);
      3'b101:  ld_ext = DW'(rd_sh[15:0]);
      3'b110:  ld_ext = DW'(rd_sh[31:0]);
      default: ld_ext = rd_sh;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: a checked op moves to REQ, ack or timeout ends it, RESP lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_req) state_d = REQ;
      REQ: begin
        if (bus.mem_ack)  state_d = RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture the op and its lane-placed request fields on accept; held stable through REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_q <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      is_load_q <= bus.is_load;
      f3_q      <= bus.funct3;
      off_q     <= off_in;
      we_q      <= bus.is_store;
      addr_q    <= {bus.addr[AW-1:LW], {LW{1'b0}}};
      be_q      <= be_full[BW-1:0];
      wdata_q   <= wdata_lane;
    end
  end

  // REQ cycle counter and flush record (flush during REQ only suppresses ld_valid)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
      if (go_req)                            flush_q <= 1'b0;
      else if (state_q == REQ && bus.flush)  flush_q <= 1'b1;
    end
  end

  // load result register, written only by an ack that arrives in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               ld_data_q <= '0;
    else if (state_q == REQ && bus.mem_ack && is_load_q)   ld_data_q <= ld_ext;
  end

  // one-cycle fault pulse; code is zero whenever no fault is signalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      if (accept && !width_ok) begin
        fault_q      <= 1'b1;
        fault_code_q <= 2'b10;
      end else if (accept && !align_ok) begin
        fault_q      <= 1'b1;
        fault_code_q <= 2'b01;
      end else if (timeout) begin
        fault_q      <= 1'b1;
        fault_code_q <= 2'b11;
      end
    end
  end

  // stall is gated by rst so an op presented during reset does not leak through
  assign bus.stall      = !rst && ((state_q == REQ) || accept);
  assign bus.mem_req    = (state_q == REQ);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.ld_data    = ld_data_q;
  assign bus.ld_valid   = (state_q == RESP) && is_load_q && !flush_q && !bus.flush;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters SHALL be:
- AW, default 32, byte-address width.
- DW, default 32, data width; legal values 32 or 64.
- TIMEOUT, default 16, maximum cycles mem_req waits for mem_ack (TIMEOUT >= 1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- op_valid, in, 1, MEM-stage instruction present this cycle.
- is_load / is_store, in, 1 each, operation class; both high is treated as no operation.
- funct3, in, 3, RISC-V access width and sign.
- addr, in, AW, effective byte address.
- st_data, in, DW, store source register value.
- flush, in, 1, squash the current MEM-stage instruction.
- mem_req, out, 1, data-memory request.
- mem_we, out, 1, request is a write.
- mem_addr, out, AW, lane-aligned address (low log2(DW/8) bits zero).
- mem_be, out, DW/8, byte enables.
- mem_wdata, out, DW, lane-placed write data.
- mem_ack, in, 1, memory completion.
- mem_rdata, in, DW, read data, valid with mem_ack.
- stall, out, 1, hold upstream pipeline stages.
- ld_data, out, DW, extended load result.
- ld_valid, out, 1, ld_data valid (one-cycle pulse).
- fault, out, 1, one-cycle fault pulse.
- fault_code, out, 2, fault type: 01 misaligned, 10 illegal width, 11 timeout.
REQ-003 Clocking SHALL be one clock (clk) with an asynchronous, active-high reset (rst).

Function
REQ-004 States SHALL be IDLE, REQ and RESP.
REQ-005 Accept: in IDLE, op_valid & (is_load XOR is_store) & !flush SHALL latch addr, st_data, funct3 and op class, and assert stall combinationally in that same cycle.
REQ-006 Checks: an accepted op with legal width and natural alignment SHALL go to REQ next cycle; otherwise it returns to IDLE, pulses fault next cycle with the matching code, and issues no mem_req.
REQ-007 Legal funct3 for DW=32: 000, 001, 010, 100, 101 (stores: 000, 001, 010); DW=64 additionally allows 011, plus 110 for loads.
REQ-008 Alignment: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
REQ-009 In REQ:
- mem_req=1 and stall=1.
- mem_we, mem_addr, mem_be and mem_wdata are registered and remain stable until mem_ack.
- mem_req is never withdrawn before mem_ack, except on timeout or reset.
REQ-010 Byte enables SHALL be the access-size mask shifted left by the lane offset addr[log2(DW/8)-1:0].
REQ-011 Write data: byte and half stores SHALL replicate the source across all lanes; full-width stores pass through unchanged.
REQ-012 On mem_ack in REQ the block SHALL go to RESP next cycle; for loads, ld_data is registered from mem_rdata:
- Lane-shifted right by the lane offset.
- Sign-extended for 000, 001 and 010 (DW=64).
- Zero-extended for 100, 101 and 110.
REQ-013 In RESP:
- stall=0.
- ld_valid=1 for one cycle for an unflushed load; ld_valid=0 for stores.
- Next state is IDLE.
- A new op presented in RESP is not accepted until IDLE.
REQ-014 Timeout: a cycle counter cleared on REQ entry SHALL, when it reaches TIMEOUT without mem_ack, deassert mem_req, return to IDLE, and pulse fault with code 11; mem_ack arriving in the same cycle as the timeout wins.
REQ-015 Flush:
- In IDLE, flush blocks acceptance.
- In REQ, flush is recorded, but the request completes per the handshake and ld_valid is suppressed.
- In RESP, flush suppresses ld_valid.
REQ-016 mem_ack outside REQ SHALL be ignored.
REQ-017 fault and ld_valid SHALL never be asserted in the same cycle.

Reset
REQ-018 Asserting rst SHALL immediately (asynchronously):
- Force IDLE and clear the counter and the flush record.
- Drive every output to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, ld_data, ld_valid, fault, fault_code.
REQ-019 Reset mid-REQ SHALL drop mem_req without waiting for mem_ack; the first accept is possible in the first cycle after rst deasserts.

Verification
REQ-020 The bench SHALL cover at least these scenarios (DW=32 unless stated):
- SB, addr 0x1003, st_data 0x000000A5, ack two cycles after req -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5A5A5A5, stall high for 4 cycles, ld_valid 0.
- LB, addr 0x2001, mem_rdata 0x1234F0AB, ack in the first REQ cycle -> ld_data 0xFFFFFFF0 with one ld_valid pulse; repeated as LBU -> 0x000000F0.
- LW at 0x2002 -> fault=1, fault_code 01, mem_req never high; funct3 011 at DW=32 -> fault_code 10.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then fault_code 11, IDLE; a second run with ack on cycle 4 -> normal completion, no fault.
- LW at 0x3000 with flush in the second REQ cycle -> mem_req held until ack, ld_valid stays 0.
- DW=64, LWU at 0x4004, mem_rdata 0x80000001_00000000 -> ld_data 0x0000000080000001; rst mid-REQ -> all outputs 0 within the same cycle.
